// File: rtl/txs_write_arbiter.sv
// Round-robin arbiter sharing the PCIe TXS Avalon-MM burst-write master
// between several DMA requesters. Whole bursts are granted at once and then
// streamed beat by beat under txs_waitrequest backpressure. Illegal burst
// lengths are dropped without bus traffic and flagged in a sticky error bit.
module txs_write_arbiter #(
  parameter int N        = 3,
  parameter int MAXBURST = 32
) (
  input  logic             c,
  input  logic             rst_n,
  input  logic             en,
  input  logic [N-1:0]     req,
  input  logic [23*N-1:0]  req_addr,
  input  logic [6*N-1:0]   req_burst,
  input  logic [128*N-1:0] req_data,
  output logic [N-1:0]     pop,
  output logic [N-1:0]     done,
  output logic [N-1:0]     err,
  input  logic             err_clr,
  output logic             busy,
  output logic             txs_write,
  output logic [22:0]      txs_address,
  output logic [5:0]       txs_burstcount,
  output logic [127:0]     txs_writedata,
  input  logic             txs_waitrequest
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {IDLE, BURST} state_t;

  state_t          state, state_n;
  logic [IW-1:0]   rr;         // round-robin search start
  logic [IW-1:0]   g;          // requester owning the burst in flight
  logic [5:0]      bc;         // beats still to be accepted
  logic [IW-1:0]   sel;
  logic            sel_valid;
  logic [22:0]     sel_addr;
  logic [5:0]      sel_burst;
  logic            sel_legal;
  logic            grant;
  logic            beat_acc;
  logic            last_acc;
  logic [N-1:0]    err_set;

  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] x);
    if (int'(x) == N - 1) return '0;
    else                  return x + 1'b1;
  endfunction

  // Pick the first asserted request at or after rr, wrapping modulo N.
  always_comb begin
    int idx;
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned, which would otherwise infer a latch.
    sel       = '0;
    sel_valid = 1'b0;
    idx       = 0;
    // Walk from the farthest candidate back to rr so the nearest one wins.
    for (int k = N - 1; k >= 0; k--) begin
      idx = (int'(rr) + k) % N;
      if (req[idx]) begin
        sel       = IW'(idx);
        sel_valid = 1'b1;
      end
    end
  end

  // Decode the selected requester's burst and the beat handshake.
  always_comb begin
    sel_addr  = req_addr[int'(sel)*23 +: 23];
    sel_burst = req_burst[int'(sel)*6 +: 6];
    sel_legal = (sel_burst != 6'd0) && (int'(sel_burst) <= MAXBURST);
    grant     = (state == IDLE) && en && sel_valid;
    beat_acc  = (state == BURST) && txs_write && !txs_waitrequest;
    last_acc  = beat_acc && (bc == 6'd1);
    err_set   = '0;
    if (grant && !sel_legal) err_set[sel] = 1'b1;
  end

  // State register.
  always_ff @(posedge c or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // Next-state logic: legal grants enter BURST, the last accepted beat leaves.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (grant && sel_legal) state_n = BURST;
      BURST:   if (last_acc)           state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Outputs that follow the state combinationally: busy, pop and data mux.
  always_comb begin
    busy          = (state == BURST);
    pop           = '0;
    if (beat_acc) pop[g] = 1'b1;
    txs_writedata = req_data[int'(g)*128 +: 128];
  end

  // Grant capture, beat counting, done/err pulses and pointer update.
  always_ff @(posedge c or negedge rst_n) begin
    if (!rst_n) begin
      rr             <= '0;
      g              <= '0;
      bc             <= '0;
      txs_write      <= 1'b0;
      txs_address    <= '0;
      txs_burstcount <= '0;
      done           <= '0;
      err            <= '0;
    end else begin
      done <= '0;
      // A new error in the same cycle as err_clr keeps its bit set.
      err  <= (err & ~{N{err_clr}}) | err_set;
      if (grant) begin
        if (sel_legal) begin
          g              <= sel;
          txs_address    <= sel_addr;
          txs_burstcount <= sel_burst;
          bc             <= sel_burst;
          txs_write      <= 1'b1;
        end else begin
          done[sel] <= 1'b1;
          rr        <= next_idx(sel);
        end
      end
      if (beat_acc) begin
        bc <= bc - 6'd1;
        if (last_acc) begin
          txs_write <= 1'b0;
          done[g]   <= 1'b1;
          rr        <= next_idx(g);
        end
      end
    end
  end

endmodule

// File: tb/tb_txs_write_arbiter.sv
// Self-checking bench for txs_write_arbiter: a table of single-burst vectors
// plus hand-written sequences for error clearing, round-robin order, enable
// gating and reset in the middle of a burst.
module tb_txs_write_arbiter;

  localparam int N = 3;

  logic             c = 1'b0;
  logic             rst_n = 1'b0;
  logic             en = 1'b1;
  logic             err_clr = 1'b0;
  logic             txs_waitrequest = 1'b0;
  logic [N-1:0]     req = '0;
  logic [23*N-1:0]  req_addr = '0;
  logic [6*N-1:0]   req_burst = '0;
  logic [128*N-1:0] req_data = '0;
  logic [N-1:0]     pop, done, err;
  logic             busy, txs_write;
  logic [22:0]      txs_address;
  logic [5:0]       txs_burstcount;
  logic [127:0]     txs_writedata;

  always #5 c = ~c;

  txs_write_arbiter #(.N(N), .MAXBURST(32)) dut (
    .c(c), .rst_n(rst_n), .en(en), .req(req), .req_addr(req_addr),
    .req_burst(req_burst), .req_data(req_data), .pop(pop), .done(done),
    .err(err), .err_clr(err_clr), .busy(busy), .txs_write(txs_write),
    .txs_address(txs_address), .txs_burstcount(txs_burstcount),
    .txs_writedata(txs_writedata), .txs_waitrequest(txs_waitrequest)
  );

  typedef struct {
    int          src;
    logic [22:0] addr;
    logic [5:0]  burst;
    logic [31:0] stall;       // beats (0-based) that see 2 waitrequest cycles
    int          exp_cycles;  // cycles with txs_write high
    logic        exp_err;
  } vec_t;

  vec_t vecs[6];

  int errors = 0;
  int checks = 0;

  // Requester / slave model and monitor state.
  int           beat[N];
  bit           one_shot[N];
  logic [31:0]  stall_mask = '0;
  int           acc_cnt = 0, wait_cnt = 0;
  logic [N-1:0] pop_s = '0, done_s = '0;
  logic [127:0] log_data[$];
  logic [22:0]  log_addr[$];
  logic [5:0]   log_bc[$];
  int           done_log[$];
  int           wcycles, busy_bad, b2b_bad, pop_bad;
  int           pops[N];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] beat_data(input int i, input int b);
    return {32'(i), 64'h0, 32'(b)};
  endfunction

  task automatic drive_data();
    for (int i = 0; i < N; i++) req_data[i*128 +: 128] = beat_data(i, beat[i]);
  endtask

  task automatic clear_logs();
    log_data.delete(); log_addr.delete(); log_bc.delete(); done_log.delete();
    wcycles = 0; busy_bad = 0; b2b_bad = 0; pop_bad = 0;
    for (int i = 0; i < N; i++) pops[i] = 0;
  endtask

  // One clock: drive after the rising edge, sample on the falling edge.
  task automatic tick();
    @(posedge c); #1;
    for (int i = 0; i < N; i++) if (pop_s[i]) beat[i]++;
    drive_data();
    txs_waitrequest = (acc_cnt < 32) ? (stall_mask[acc_cnt] && wait_cnt < 2) : 1'b0;
    @(negedge c);
    if (txs_write) begin
      wcycles++;
      if (!txs_waitrequest) begin
        log_data.push_back(txs_writedata);
        log_addr.push_back(txs_address);
        log_bc.push_back(txs_burstcount);
        acc_cnt++;
        wait_cnt = 0;
      end else begin
        wait_cnt++;
      end
    end
    if (busy !== txs_write) busy_bad++;
    if ($countones(pop) != ((txs_write && !txs_waitrequest) ? 1 : 0)) pop_bad++;
    if (done != '0 && txs_write) b2b_bad++;
    for (int i = 0; i < N; i++) pops[i] += int'(pop[i]);
    pop_s  = pop;
    done_s = done;
    for (int i = 0; i < N; i++) begin
      if (done[i]) begin
        done_log.push_back(i);
        beat[i] = 0;
        if (one_shot[i]) req[i] = 1'b0;
      end
    end
    if (done != '0) begin
      acc_cnt  = 0;
      wait_cnt = 0;
    end
  endtask

  task automatic wait_dones(input int n, input string what);
    int t = 0;
    while (done_log.size() < n && t < 400) begin tick(); t++; end
    check(what, done_log.size(), n);
  endtask

  task automatic wait_beats(input int n, input string what);
    int t = 0;
    while (log_data.size() < n && t < 400) begin tick(); t++; end
    check(what, log_data.size(), n);
  endtask

  task automatic set_req(input int s, input logic [22:0] a, input logic [5:0] b, input bit os);
    req_addr[s*23 +: 23] = a;
    req_burst[s*6 +: 6]  = b;
    one_shot[s]          = os;
    req[s]               = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge c);
    rst_n = 1'b0;
    req = '0;
    stall_mask = '0;
    acc_cnt = 0; wait_cnt = 0; pop_s = '0; done_s = '0;
    for (int i = 0; i < N; i++) beat[i] = 0;
    drive_data();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic run_vector(input vec_t v);
    int  bad;
    bit  legal;
    int  nb;
    legal = (v.burst != 0) && (v.burst <= 32);
    nb    = legal ? int'(v.burst) : 0;
    clear_logs();
    stall_mask = v.stall;
    set_req(v.src, v.addr, v.burst, 1'b1);
    tick();
    if (!legal) begin
      check($sformatf("drop_done_src%0d", v.src), done_s[v.src], 1'b1);
      tick(); tick();
    end else begin
      check($sformatf("grant_latency_src%0d", v.src), txs_write, 1'b1);
      wait_dones(1, $sformatf("done_seen_src%0d", v.src));
      tick(); tick();
    end
    check($sformatf("write_cycles_src%0d", v.src), wcycles, v.exp_cycles);
    check($sformatf("beats_src%0d", v.src), log_data.size(), nb);
    check($sformatf("pops_src%0d", v.src), pops[v.src], nb);
    check($sformatf("done_count_src%0d", v.src), done_log.size(), 1);
    if (done_log.size() > 0) check($sformatf("done_which_src%0d", v.src), done_log[0], v.src);
    check($sformatf("err_src%0d", v.src), err[v.src], v.exp_err);
    bad = 0;
    for (int k = 0; k < log_data.size(); k++)
      if (log_data[k] !== beat_data(v.src, k) || log_addr[k] !== v.addr || log_bc[k] !== v.burst)
        bad++;
    check($sformatf("beat_stream_src%0d", v.src), bad, 0);
    check($sformatf("protocol_src%0d", v.src), busy_bad + b2b_bad + pop_bad, 0);
    stall_mask = '0;
  endtask

  initial begin
    int exp_order[6];
    int bad;

    vecs[0] = '{src: 0, addr: 23'h000100, burst: 6'd8,  stall: 32'h0, exp_cycles: 8,  exp_err: 1'b0};
    vecs[1] = '{src: 1, addr: 23'h7ffff0, burst: 6'd4,  stall: 32'ha, exp_cycles: 8,  exp_err: 1'b0};
    vecs[2] = '{src: 2, addr: 23'h000200, burst: 6'd0,  stall: 32'h0, exp_cycles: 0,  exp_err: 1'b1};
    vecs[3] = '{src: 2, addr: 23'h000300, burst: 6'd33, stall: 32'h0, exp_cycles: 0,  exp_err: 1'b1};
    vecs[4] = '{src: 0, addr: 23'h000000, burst: 6'd32, stall: 32'h0, exp_cycles: 32, exp_err: 1'b0};
    vecs[5] = '{src: 1, addr: 23'h123456, burst: 6'd1,  stall: 32'h0, exp_cycles: 1,  exp_err: 1'b0};

    for (int i = 0; i < N; i++) begin beat[i] = 0; one_shot[i] = 1'b1; end
    drive_data();
    clear_logs();

    // Reset state.
    repeat (2) @(negedge c);
    check("rst_txs_write", txs_write, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_pop_done_err", {pop, done, err}, '0);
    check("rst_address", txs_address, 23'h0);
    check("rst_burstcount", txs_burstcount, 6'h0);
    rst_n = 1'b1;
    tick();

    for (int v = 0; v < 6; v++) run_vector(vecs[v]);

    // err_clr clears the sticky bit.
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("err_clr_clears", err, 3'b000);

    // New error and err_clr in the same cycle: the error wins.
    set_req(2, 23'h000400, 6'd0, 1'b1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("err_beats_clr", err, 3'b100);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("err_clr_again", err, 3'b000);

    // rr advances past a dropped requester: drop 0, then 0 and 2 compete.
    do_reset();
    clear_logs();
    set_req(0, 23'h000500, 6'd33, 1'b1);
    tick();
    check("drop0_done", done_s, 3'b001);
    check("drop0_err", err, 3'b001);
    clear_logs();
    set_req(0, 23'h000500, 6'd2, 1'b1);
    set_req(2, 23'h000600, 6'd2, 1'b1);
    wait_dones(2, "drop_then_two_done");
    if (done_log.size() >= 2) begin
      check("rr_after_drop_first", done_log[0], 2);
      check("rr_after_drop_second", done_log[1], 0);
    end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;

    // Round-robin with all three requests held high, bursts of 2.
    do_reset();
    clear_logs();
    set_req(0, 23'h001000, 6'd2, 1'b0);
    set_req(1, 23'h002000, 6'd2, 1'b0);
    set_req(2, 23'h003000, 6'd2, 1'b0);
    wait_dones(6, "rr_six_done");
    req = '0;
    tick(); tick();
    exp_order = '{0, 1, 2, 0, 1, 2};
    bad = 0;
    for (int k = 0; k < 6; k++) if (k >= done_log.size() || done_log[k] != exp_order[k]) bad++;
    check("rr_grant_order", bad, 0);
    check("rr_write_cycles", wcycles, 12);
    bad = 0;
    for (int k = 0; k < log_data.size(); k++)
      if (log_data[k] !== beat_data(exp_order[(k/2) % 6], k % 2)) bad++;
    check("rr_data", bad, 0);
    check("rr_idle_gap", b2b_bad, 0);
    for (int i = 0; i < N; i++) one_shot[i] = 1'b1;

    // Enable drops during beat 3 of a 16-beat burst: burst still completes.
    clear_logs();
    set_req(0, 23'h004000, 6'd16, 1'b1);
    wait_beats(2, "en_reach_beat3");
    en = 1'b0;
    wait_dones(1, "en_burst_done");
    check("en_burst_cycles", wcycles, 16);
    check("en_burst_pops", pops[0], 16);
    clear_logs();
    set_req(0, 23'h005000, 6'd2, 1'b1);
    set_req(1, 23'h006000, 6'd2, 1'b1);
    set_req(2, 23'h007000, 6'd2, 1'b1);
    repeat (10) tick();
    check("en_low_no_write", wcycles, 0);
    check("en_low_no_done", done_log.size(), 0);
    en = 1'b1;
    wait_dones(1, "en_high_grant");
    req = '0;
    if (done_log.size() > 0) check("en_grant_at_rr", done_log[0], 1);
    if (log_addr.size() > 0) check("en_grant_addr", log_addr[0], 23'h006000);
    tick(); tick();

    // Reset asserted during beat 5 of an 8-beat burst.
    clear_logs();
    set_req(0, 23'h008000, 6'd8, 1'b1);
    wait_beats(5, "rst_reach_beat5");
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_write", txs_write, 1'b0);
    check("rst_mid_busy", busy, 1'b0);
    check("rst_mid_pop", pop, 3'b000);
    req = '0;
    pop_s = '0; done_s = '0; acc_cnt = 0; wait_cnt = 0;
    for (int i = 0; i < N; i++) beat[i] = 0;
    drive_data();
    set_req(1, 23'h009000, 6'd3, 1'b1);
    tick();
    rst_n = 1'b1;
    clear_logs();
    wait_dones(1, "rst_after_done");
    if (done_log.size() > 0) check("rst_first_grant", done_log[0], 1);
    if (log_addr.size() > 0) check("rst_first_addr", log_addr[0], 23'h009000);
    check("rst_after_beats", log_data.size(), 3);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
